// File: rtl/btb_pkg.sv
// Shared types and geometry for the set-associative branch target buffer.
// Geometry is fixed here; every BTB file derives its widths from it.
package btb_pkg;

    localparam int VADDR_BITS = 40;
    localparam int N_SETS     = 64;
    localparam int N_WAYS     = 2;
    localparam int TAG_BITS   = 20;
    localparam int INSN_SHIFT = 1;

    localparam int IDX_BITS = $clog2(N_SETS);
    localparam int WAY_BITS = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    typedef logic [IDX_BITS-1:0] btb_idx_t;
    typedef logic [TAG_BITS-1:0] btb_tag_t;
    typedef logic [WAY_BITS-1:0] btb_way_t;

    typedef struct packed {
        logic                  valid;
        btb_tag_t              tag;
        logic [VADDR_BITS-1:0] target;
        logic                  is_br;
        logic                  is_jal;
    } btb_entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } btb_state_t;

    // Set index: the bits just above the instruction granule.
    function automatic btb_idx_t pc_idx(input logic [VADDR_BITS-1:0] pc);
        return btb_idx_t'(pc >> INSN_SHIFT);
    endfunction

    // Partial tag: the bits above the index; higher bits alias.
    function automatic btb_tag_t pc_tag(input logic [VADDR_BITS-1:0] pc);
        return btb_tag_t'(pc >> (INSN_SHIFT + IDX_BITS));
    endfunction

endpackage

// File: rtl/btb_way_array.sv
// One way of the BTB: N_SETS entries, one write port, a registered
// lookup read, a per-set valid clear and a combinational tag probe.
module btb_way_array
    import btb_pkg::*;
(
    input  logic       clock,
    input  logic       clear_en,
    input  btb_idx_t   clear_idx,
    input  logic       wr_en,
    input  btb_idx_t   wr_idx,
    input  btb_entry_t wr_entry,
    input  btb_idx_t   rd_idx,
    output btb_entry_t rd_entry,
    input  btb_idx_t   probe_idx,
    output logic       probe_valid,
    output btb_tag_t   probe_tag
);

    logic [N_SETS-1:0]     valid_q;
    btb_tag_t              tag_q    [N_SETS];
    logic [VADDR_BITS-1:0] target_q [N_SETS];
    logic [N_SETS-1:0]     br_q;
    logic [N_SETS-1:0]     jal_q;

    // Valid bits: the clear sequence wins over a training write.
    always_ff @(posedge clock) begin
        if (clear_en) begin
            valid_q[clear_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_entry.valid;
        end
    end

    // Payload storage; only meaningful while the valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_entry.tag;
            target_q[wr_idx] <= wr_entry.target;
            br_q[wr_idx]     <= wr_entry.is_br;
            jal_q[wr_idx]    <= wr_entry.is_jal;
        end
    end

    // Lookup read: old contents on a same-cycle write (no bypass).
    always_ff @(posedge clock) begin
        rd_entry.valid  <= valid_q[rd_idx];
        rd_entry.tag    <= tag_q[rd_idx];
        rd_entry.target <= target_q[rd_idx];
        rd_entry.is_br  <= br_q[rd_idx];
        rd_entry.is_jal <= jal_q[rd_idx];
    end

    // Probe lets the update path pick its victim in the same cycle.
    always_comb begin
        probe_valid = valid_q[probe_idx];
        probe_tag   = tag_q[probe_idx];
    end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB: clear FSM, registered lookup with tag compare,
// and training/invalidation with round-robin victim selection.
module btb_set_assoc
    import btb_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_busy,
    input  logic                  req_valid,
    input  logic [VADDR_BITS-1:0] req_pc,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [VADDR_BITS-1:0] resp_target,
    output logic                  resp_is_br,
    output logic                  resp_is_jal,
    input  logic                  update_valid,
    input  logic [VADDR_BITS-1:0] update_pc,
    input  logic [VADDR_BITS-1:0] update_target,
    input  logic                  update_is_br,
    input  logic                  update_is_jal
);

    btb_state_t state_q;
    btb_state_t state_d;
    btb_idx_t   cnt_q;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT after the last set is cleared.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: if (cnt_q == btb_idx_t'(N_SETS - 1)) state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        init_busy = (state_q == INIT);
    end

    // Clear counter walks every set once while in INIT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    btb_idx_t req_idx;
    btb_idx_t upd_idx;
    btb_tag_t upd_tag;
    logic     req_fire;
    logic     upd_fire;
    logic     upd_train;

    assign req_idx   = pc_idx(req_pc);
    assign upd_idx   = pc_idx(update_pc);
    assign upd_tag   = pc_tag(update_pc);
    assign req_fire  = req_valid & ~init_busy;
    assign upd_fire  = update_valid & ~init_busy;
    assign upd_train = update_is_br | update_is_jal;

    logic     resp_valid_q;
    btb_tag_t req_tag_q;

    // Lookup pipeline: remember acceptance and tag for the compare.
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            req_tag_q    <= '0;
        end else begin
            resp_valid_q <= req_fire;
            req_tag_q    <= pc_tag(req_pc);
        end
    end

    btb_entry_t        rd_entry    [N_WAYS];
    logic [N_WAYS-1:0] probe_valid;
    btb_tag_t          probe_tag   [N_WAYS];
    logic [N_WAYS-1:0] way_we;
    logic              wr_en;
    btb_way_t          wr_way;
    btb_entry_t        wr_entry;

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        assign way_we[w] = wr_en && (wr_way == btb_way_t'(w));

        btb_way_array u_array (
            .clock      (clock),
            .clear_en   (init_busy),
            .clear_idx  (cnt_q),
            .wr_en      (way_we[w]),
            .wr_idx     (upd_idx),
            .wr_entry   (wr_entry),
            .rd_idx     (req_idx),
            .rd_entry   (rd_entry[w]),
            .probe_idx  (upd_idx),
            .probe_valid(probe_valid[w]),
            .probe_tag  (probe_tag[w])
        );
    end

    logic                  hit;
    logic [VADDR_BITS-1:0] hit_target;
    logic                  hit_br;
    logic                  hit_jal;

    // Tag compare; scanning downward leaves the lowest matching way.
    always_comb begin
        hit        = 1'b0;
        hit_target = '0;
        hit_br     = 1'b0;
        hit_jal    = 1'b0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (rd_entry[w].valid && rd_entry[w].tag == req_tag_q) begin
                hit        = 1'b1;
                hit_target = rd_entry[w].target;
                hit_br     = rd_entry[w].is_br;
                hit_jal    = rd_entry[w].is_jal;
            end
        end
    end

    // Response: everything is zero unless a valid lookup hit.
    always_comb begin
        resp_valid  = resp_valid_q;
        resp_hit    = resp_valid_q & hit;
        resp_target = resp_hit ? hit_target : '0;
        resp_is_br  = resp_hit & hit_br;
        resp_is_jal = resp_hit & hit_jal;
    end

    logic     match_any;
    btb_way_t match_way;
    logic     free_any;
    btb_way_t free_way;

    // Probe scan: lowest way holding the tag and lowest empty way.
    always_comb begin
        match_any = 1'b0;
        match_way = '0;
        free_any  = 1'b0;
        free_way  = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (probe_valid[w] && probe_tag[w] == upd_tag) begin
                match_any = 1'b1;
                match_way = btb_way_t'(w);
            end
            if (!probe_valid[w]) begin
                free_any = 1'b1;
                free_way = btb_way_t'(w);
            end
        end
    end

    btb_way_t rr_q [N_SETS];
    logic     rr_adv;

    // Victim choice: reuse the tag's way, else an empty way, else round-robin.
    always_comb begin
        wr_en  = 1'b0;
        wr_way = match_way;
        rr_adv = 1'b0;
        if (upd_fire) begin
            if (match_any) begin
                wr_en = 1'b1;
            end else if (upd_train) begin
                wr_en = 1'b1;
                if (free_any) begin
                    wr_way = free_way;
                end else begin
                    wr_way = rr_q[upd_idx];
                    rr_adv = 1'b1;
                end
            end
        end
        wr_entry.valid  = upd_train;
        wr_entry.tag    = upd_tag;
        wr_entry.target = update_target;
        wr_entry.is_br  = update_is_br;
        wr_entry.is_jal = update_is_jal;
    end

    // Round-robin pointers only move when a valid entry is evicted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < N_SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (rr_adv) begin
            if (rr_q[upd_idx] == btb_way_t'(N_WAYS - 1)) begin
                rr_q[upd_idx] <= '0;
            end else begin
                rr_q[upd_idx] <= rr_q[upd_idx] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Randomized scoreboard bench for btb_set_assoc with an array-based
// reference model of the BTB contents and replacement order.
module tb_btb_set_assoc;
    import btb_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  init_busy;
    logic                  req_valid = 1'b0;
    logic [VADDR_BITS-1:0] req_pc = '0;
    logic                  resp_valid;
    logic                  resp_hit;
    logic [VADDR_BITS-1:0] resp_target;
    logic                  resp_is_br;
    logic                  resp_is_jal;
    logic                  update_valid = 1'b0;
    logic [VADDR_BITS-1:0] update_pc = '0;
    logic [VADDR_BITS-1:0] update_target = '0;
    logic                  update_is_br = 1'b0;
    logic                  update_is_jal = 1'b0;

    btb_set_assoc dut (
        .clock        (clock),
        .reset        (reset),
        .init_busy    (init_busy),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_target  (resp_target),
        .resp_is_br   (resp_is_br),
        .resp_is_jal  (resp_is_jal),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_target(update_target),
        .update_is_br (update_is_br),
        .update_is_jal(update_is_jal)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                    cyc;
        bit                    hit;
        logic [VADDR_BITS-1:0] tgt;
        bit                    br;
        bit                    jal;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   live  = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference model: plain arrays per set and way.
    bit                    m_v   [N_SETS][N_WAYS];
    logic [TAG_BITS-1:0]   m_tag [N_SETS][N_WAYS];
    logic [VADDR_BITS-1:0] m_tgt [N_SETS][N_WAYS];
    bit                    m_br  [N_SETS][N_WAYS];
    bit                    m_jal [N_SETS][N_WAYS];
    int                    m_rr  [N_SETS];

    function automatic int m_idx(logic [VADDR_BITS-1:0] pc);
        logic [63:0] p;
        p = 64'(pc);
        return int'((p / (64'd1 << INSN_SHIFT)) % 64'(N_SETS));
    endfunction

    function automatic logic [TAG_BITS-1:0] m_tagof(logic [VADDR_BITS-1:0] pc);
        logic [63:0] p;
        p = 64'(pc) / (64'd1 << (INSN_SHIFT + $clog2(N_SETS)));
        p = p % (64'd1 << TAG_BITS);
        return p[TAG_BITS-1:0];
    endfunction

    task automatic m_clear();
        for (int s = 0; s < N_SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < N_WAYS; w++) m_v[s][w] = 1'b0;
        end
    endtask

    task automatic m_lookup(logic [VADDR_BITS-1:0] pc, output exp_t e);
        int s;
        s = m_idx(pc);
        e.cyc = 0; e.hit = 1'b0; e.tgt = '0; e.br = 1'b0; e.jal = 1'b0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (!e.hit && m_v[s][w] && m_tag[s][w] == m_tagof(pc)) begin
                e.hit = 1'b1;
                e.tgt = m_tgt[s][w];
                e.br  = m_br[s][w];
                e.jal = m_jal[s][w];
            end
        end
    endtask

    task automatic m_update(logic [VADDR_BITS-1:0] pc,
                            logic [VADDR_BITS-1:0] tgt, bit br, bit jal);
        int s;
        int hitw;
        int freew;
        int w;
        s = m_idx(pc);
        hitw = -1;
        freew = -1;
        for (int i = 0; i < N_WAYS; i++) begin
            if (hitw < 0 && m_v[s][i] && m_tag[s][i] == m_tagof(pc)) hitw = i;
            if (freew < 0 && !m_v[s][i]) freew = i;
        end
        if (!br && !jal) begin
            if (hitw >= 0) m_v[s][hitw] = 1'b0;
            return;
        end
        if (hitw >= 0) w = hitw;
        else if (freew >= 0) w = freew;
        else begin
            w = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % N_WAYS;
        end
        m_v[s][w]   = 1'b1;
        m_tag[s][w] = m_tagof(pc);
        m_tgt[s][w] = tgt;
        m_br[s][w]  = br;
        m_jal[s][w] = jal;
    endtask

    // One cycle of stimulus; the lookup sees the model before the update.
    task automatic step(bit rv, logic [VADDR_BITS-1:0] rpc, bit uv,
                        logic [VADDR_BITS-1:0] upc,
                        logic [VADDR_BITS-1:0] utgt, bit ubr, bit ujal);
        exp_t e;
        req_valid     = rv;
        req_pc        = rpc;
        update_valid  = uv;
        update_pc     = upc;
        update_target = utgt;
        update_is_br  = ubr;
        update_is_jal = ujal;
        if (live && rv) begin
            m_lookup(rpc, e);
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        if (live && uv) m_update(upc, utgt, ubr, ujal);
        @(posedge clock);
        #1;
    endtask

    // Few tags and sets so hits and evictions are frequent; upper bits alias.
    function automatic logic [VADDR_BITS-1:0] rand_pc();
        logic [VADDR_BITS-1:0] p;
        p = VADDR_BITS'($urandom_range(0, 3)) << 7;
        p = p | (VADDR_BITS'($urandom_range(0, 3)) << 1);
        p = p | VADDR_BITS'($urandom_range(0, 1));
        p = p | (VADDR_BITS'($urandom_range(0, 8191)) << 27);
        return p;
    endfunction

    task automatic rand_step();
        logic [63:0] t;
        int          k;
        bit          br;
        bit          jal;
        t = {$urandom, $urandom};
        k = $urandom_range(0, 9);
        br  = (k >= 2 && k < 5) || k >= 8;
        jal = (k >= 5);
        step($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 1) == 1,
             rand_pc(), t[VADDR_BITS-1:0], br, jal);
    endtask

    // Reset for n edges, then check the clear sequence length.
    task automatic do_reset(int n);
        int busy;
        reset = 1'b0;
        live = 1'b0;
        update_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        m_clear();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_resp_target", 64'(resp_target), 64'd0);
        chk("rst_resp_type", 64'({resp_is_br, resp_is_jal}), 64'd0);
        chk("rst_init_busy", 64'(init_busy), 64'd1);
        req_valid = 1'b0;
        reset = 1'b1;
        busy = 0;
        for (int i = 0; i < N_SETS; i++) begin
            if (init_busy) busy++;
            rand_step();
        end
        chk("init_busy_cycles", 64'(busy), 64'(N_SETS));
        chk("init_busy_low", 64'(init_busy), 64'd0);
        live = 1'b1;
    endtask

    // Monitor: pops one expectation per presented response.
    always @(negedge clock) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("resp_missing_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_spurious", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_hit", 64'(resp_hit), 64'(e.hit));
                chk("resp_target", 64'(resp_target), 64'(e.tgt));
                chk("resp_is_br", 64'(resp_is_br), 64'(e.br));
                chk("resp_is_jal", 64'(resp_is_jal), 64'(e.jal));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        // Empty table: everything misses.
        step(1, 40'h1000, 0, '0, '0, 0, 0);
        step(1, 40'h80, 0, '0, '0, 0, 0);

        // Three tags into set 0 forces one round-robin eviction.
        step(0, '0, 1, 40'h0,   40'hA, 0, 1);
        step(0, '0, 1, 40'h80,  40'hB, 0, 1);
        step(0, '0, 1, 40'h100, 40'hC, 0, 1);
        step(1, 40'h0,   0, '0, '0, 0, 0);
        step(1, 40'h80,  0, '0, '0, 0, 0);
        step(1, 40'h100, 0, '0, '0, 0, 0);

        // Train then look up on the following cycle.
        step(0, '0, 1, 40'h1000, 40'h2040, 1, 0);
        step(1, 40'h1000, 0, '0, '0, 0, 0);

        // Invalidate, look up, retrain, look up.
        step(0, '0, 1, 40'h1000, '0, 0, 0);
        step(1, 40'h1000, 0, '0, '0, 0, 0);
        step(0, '0, 1, 40'h1000, 40'h3000, 1, 0);
        step(1, 40'h1000, 0, '0, '0, 0, 0);

        // Same-cycle lookup and update: old target, then new one.
        step(1, 40'h1000, 1, 40'h1000, 40'h4000, 1, 0);
        step(1, 40'h1000, 0, '0, '0, 0, 0);

        // Both type bits, and aliasing through upper PC bits.
        step(0, '0, 1, 40'h42, 40'h99, 1, 1);
        step(1, 40'hF0_0000_0042, 0, '0, '0, 0, 0);

        repeat (1500) rand_step();

        // Make 0x1000 hit, then reset with that lookup still asserted.
        step(0, '0, 1, 40'h1000, 40'h5000, 0, 1);
        step(1, 40'h1000, 0, '0, '0, 0, 0);
        req_valid = 1'b1;
        req_pc = 40'h1000;
        do_reset(1);

        step(1, 40'h1000, 0, '0, '0, 0, 0);
        step(1, 40'h100, 0, '0, '0, 0, 0);
        repeat (800) rand_step();

        step(0, '0, 0, '0, '0, 0, 0);
        step(0, '0, 0, '0, '0, 0, 0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
